// File: rtl/mux8_scan_sequencer.sv
// Scan sequencer for an 8:1 active-low-enabled mux: walks the enabled channels in
// ascending order, samples the mux output after a settle delay, presents an 8-bit word.
module mux8_scan_sequencer #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] mask,
  output logic [2:0] sel,
  output logic       en_n,
  input  logic       mux_y,
  output logic [7:0] word,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t           r_state;
  logic [7:0]       r_mask;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0]       w_first_sel;
  logic [2:0]       w_next_sel;
  logic             w_next_any;

  // Lowest enabled channel of the incoming mask (used when a start is accepted)
  always_comb begin
    w_first_sel = 3'd0;
    for (int c = 7; c >= 0; c--) begin
      if (mask[c]) w_first_sel = 3'(c);
    end
  end

  // Next enabled channel strictly above the current select
  always_comb begin
    w_next_sel = 3'd0;
    w_next_any = 1'b0;
    for (int c = 7; c >= 0; c--) begin
      if (r_mask[c] && (c > int'(sel))) begin
        w_next_sel = 3'(c);
        w_next_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mask  <= 8'd0;
      r_cnt   <= '0;
      sel     <= 3'd0;
      en_n    <= 1'b1;
      word    <= 8'd0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else if (abort) begin
      r_state <= ST_IDLE;
      en_n    <= 1'b1;
      valid   <= 1'b0;
      word    <= 8'd0;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mask <= mask;
            word   <= 8'd0;
            busy   <= 1'b1;
            if (mask == 8'd0) begin
              r_state <= ST_HOLD;
            end else begin
              sel     <= w_first_sel;
              r_cnt   <= CNT_LOAD;
              en_n    <= 1'b0;
              r_state <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) r_state <= ST_SAMPLE;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        ST_SAMPLE: begin
          word[sel] <= mux_y;
          if (w_next_any) begin
            sel     <= w_next_sel;
            r_cnt   <= CNT_LOAD;
            r_state <= ST_SETTLE;
          end else begin
            en_n    <= 1'b1;
            valid   <= 1'b1;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // An empty scan enters HOLD with valid low; it rises one cycle later
          if (valid && ready) begin
            valid   <= 1'b0;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            valid   <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_scan_sequencer.sv
// Bench for mux8_scan_sequencer: two instances (settle 1 and 3) share the control inputs
// and are checked every cycle against a scan-schedule model built from the channel list.
module tb_mux8_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       ready;
  logic [7:0] mask;
  logic [7:0] tb_data;

  logic [2:0] sel_o   [2];
  logic       en_n_o  [2];
  logic       valid_o [2];
  logic       busy_o  [2];
  logic       mux_y_w [2];
  logic [7:0] word_o  [2];

  int n_assert = 0;
  int n_fail   = 0;
  int m_sel [2];

  // Behavioural 8:1 mux: true output is forced low while disabled
  assign mux_y_w[0] = en_n_o[0] ? 1'b0 : tb_data[sel_o[0]];
  assign mux_y_w[1] = en_n_o[1] ? 1'b0 : tb_data[sel_o[1]];

  mux8_scan_sequencer #(.SETTLE(1), .CNT_W(4)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mask(mask),
    .sel(sel_o[0]), .en_n(en_n_o[0]), .mux_y(mux_y_w[0]), .word(word_o[0]),
    .valid(valid_o[0]), .ready(ready), .busy(busy_o[0])
  );

  mux8_scan_sequencer #(.SETTLE(3), .CNT_W(4)) dut_s3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mask(mask),
    .sel(sel_o[1]), .en_n(en_n_o[1]), .mux_y(mux_y_w[1]), .word(word_o[1]),
    .valid(valid_o[1]), .ready(ready), .busy(busy_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input int i, input string tag, input int e_sel, input logic e_en_n,
                          input logic e_valid, input logic e_busy, input logic [7:0] e_word,
                          input logic do_word);
    chk($sformatf("%s[s%0d].sel", tag, settle_of(i)), 32'(sel_o[i]), 32'(e_sel));
    chk($sformatf("%s[s%0d].en_n", tag, settle_of(i)), 32'(en_n_o[i]), 32'(e_en_n));
    chk($sformatf("%s[s%0d].valid", tag, settle_of(i)), 32'(valid_o[i]), 32'(e_valid));
    chk($sformatf("%s[s%0d].busy", tag, settle_of(i)), 32'(busy_o[i]), 32'(e_busy));
    if (do_word) chk($sformatf("%s[s%0d].word", tag, settle_of(i)), 32'(word_o[i]), 32'(e_word));
  endtask

  // Expected outputs k cycles after the accepting edge, from the ordered channel list
  task automatic expect_at(input int i, input int k, input logic [7:0] m, input logic [7:0] d,
                           output int e_sel);
    int ch[$];
    int s, n, lat;
    logic [7:0] w;
    s = settle_of(i);
    for (int c = 0; c < 8; c++) if (m[c]) ch.push_back(c);
    n = ch.size();
    lat = (n == 0) ? 1 : n * (s + 1);
    if (n == 0) begin
      e_sel = m_sel[i];
      chk_inst(i, $sformatf("empty k%0d", k), e_sel, 1'b1, (k >= 1), 1'b1, 8'd0, 1'b1);
    end else if (k < lat) begin
      e_sel = ch[k / (s + 1)];
      w = 8'd0;
      for (int j = 0; j < n; j++) if ((j + 1) * (s + 1) <= k) w[ch[j]] = d[ch[j]];
      chk_inst(i, $sformatf("scan k%0d", k), e_sel, 1'b0, 1'b0, 1'b1, w, 1'b1);
    end else begin
      e_sel = ch[n - 1];
      chk_inst(i, $sformatf("hold k%0d", k), e_sel, 1'b1, 1'b1, 1'b1, d & m, 1'b1);
    end
  endtask

  task automatic scan(input logic [7:0] m, input logic [7:0] d, input int abort_k, input int restart_k);
    int e_sel[2];
    int lat_max;
    int n;
    n = $countones(m);
    lat_max = (n == 0) ? 1 : n * 4;
    tb_data = d;
    mask    = m;
    start   = 1'b1;
    ready   = 1'b0;
    tick();
    start = 1'b0;
    mask  = 8'($urandom);
    for (int k = 0; k <= lat_max + 5; k++) begin
      if (k > 0) tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) expect_at(i, k, m, d, e_sel[i]);
      if (k == abort_k) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
          m_sel[i] = e_sel[i];
          chk_inst(i, "abort", e_sel[i], 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
        end
        for (int t = 0; t < 3; t++) begin
          tick();
          for (int i = 0; i < 2; i++)
            chk_inst(i, "post_abort", e_sel[i], 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
        end
        return;
      end
      if (k == restart_k) begin
        start = 1'b1;
        mask  = 8'($urandom);
      end
    end
    // Completion handshake with a coincident start, which must be ignored
    ready = 1'b1;
    start = 1'b1;
    tick();
    ready = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_sel[i] = e_sel[i];
      chk_inst(i, "release", e_sel[i], 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    end
    tick();
    for (int i = 0; i < 2; i++)
      chk_inst(i, "idle_after", e_sel[i], 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    ready   = 1'b0;
    mask    = 8'd0;
    tb_data = 8'd0;
    m_sel[0] = 0;
    m_sel[1] = 0;
    repeat (2) tick();
    for (int i = 0; i < 2; i++) chk_inst(i, "reset", 0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
    rst_n = 1'b1;
    tick();

    // Reset while settling on channel 3
    tb_data = 8'hFF;
    mask    = 8'h08;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("midscan.sel_before", 32'(sel_o[0]), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) chk_inst(i, "reset_mid", 0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) chk_inst(i, "reset_rel", 0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);

    // Directed scans: full, sparse, empty, ignored start, abort, single channel
    scan(8'hFF, 8'h4D, -1, -1);
    scan(8'h84, 8'h4D, -1, -1);
    scan(8'h00, 8'hA5, -1, -1);
    scan(8'h5A, 8'h3C, -1, 0);
    scan(8'h06, 8'hFF, 1, -1);
    scan(8'h01, 8'h01, -1, -1);
    scan(8'h80, 8'h80, -1, -1);

    for (int r = 0; r < 25; r++) begin
      int ak, rk;
      ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      rk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1;
      scan(8'($urandom), 8'($urandom), ak, rk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
